// File: rtl/sfx_scheduler_if.sv
// Game-event and I2S-player signals seen by the sound-effect scheduler.
// The scheduler uses the slave view; the game/player side uses master.
interface sfx_scheduler_if #(
  parameter int SEL_W = 4
);
  logic             ev_player_hit;
  logic             ev_fire;
  logic             ev_alien_hit;
  logic             ufo_active;
  logic             ufo_hit;
  logic             march_enable;
  logic             theme_ended;
  logic [SEL_W-1:0] select;
  logic             new_trackN;
  logic             busy;
  logic [2:0]       pending;

  modport master (
    output ev_player_hit, ev_fire, ev_alien_hit, ufo_active, ufo_hit,
           march_enable, theme_ended,
    input  select, new_trackN, busy, pending
  );

  modport slave (
    input  ev_player_hit, ev_fire, ev_alien_hit, ufo_active, ufo_hit,
           march_enable, theme_ended,
    output select, new_trackN, busy, pending
  );
endinterface

// File: rtl/sfx_scheduler.sv
// Queues game sound events, picks a track by fixed priority and drives the
// I2S player's select / start strobe, with a silence gap between tracks.
//
// state | meaning
// IDLE  | silence, waiting for a request
// START | one-cycle start strobe with the chosen track id
// PLAY  | track running, watching for preemption or end of track
// GAP   | silence between consecutive tracks
module sfx_scheduler #(
  parameter int SEL_W        = 4,
  parameter int GAP_CYCLES   = 64,
  parameter int GUARD_CYCLES = 4,
  parameter int MIN_HOLD     = 1024
) (
  input  logic          MCLK,
  input  logic          reset,
  sfx_scheduler_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_PLAY, S_GAP} state_t;

  localparam logic [2:0] ID_MARCH   = 3'd0;
  localparam logic [2:0] ID_EXPLODE = 3'd1;
  localparam logic [2:0] ID_FIRE    = 3'd2;
  localparam logic [2:0] ID_INVADER = 3'd3;
  localparam logic [2:0] ID_UFO     = 3'd4;
  localparam logic [2:0] ID_SILENCE = 3'd5;

  localparam int GUARD_W = $clog2(GUARD_CYCLES + 2);
  localparam int HOLD_W  = $clog2(MIN_HOLD + 2);
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

  state_t             state_q, state_d;
  logic [2:0]         id_q, id_d;
  logic [2:0]         pending_q;
  logic [SEL_W-1:0]   select_q;
  logic               new_track_n_q;
  logic               busy_q;
  logic [GUARD_W-1:0] guard_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [GAP_W-1:0]   gap_q;

  logic [2:0] ev_vec;
  logic [2:0] grant_clr;
  logic [2:0] pend_mask;
  logic [2:0] pend_id;
  logic       pend_any;
  logic       hold_done;
  logic       one_shot;

  assign ev_vec = {bus.ev_alien_hit, bus.ev_fire, bus.ev_player_hit};

  always_comb begin
    pend_any  = |pending_q;
    pend_id   = ID_INVADER;
    pend_mask = 3'b100;
    if (pending_q[0]) begin
      pend_id   = ID_EXPLODE;
      pend_mask = 3'b001;
    end else if (pending_q[1]) begin
      pend_id   = ID_FIRE;
      pend_mask = 3'b010;
    end
    hold_done = (hold_q >= HOLD_W'(MIN_HOLD));
    one_shot  = (id_q == ID_EXPLODE) || (id_q == ID_FIRE) || (id_q == ID_INVADER);

    state_d   = state_q;
    id_d      = id_q;
    grant_clr = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (pend_any) begin
          state_d   = S_START;
          id_d      = pend_id;
          grant_clr = pend_mask;
        end else if (bus.ufo_active) begin
          state_d = S_START;
          id_d    = ID_UFO;
        end else if (bus.march_enable) begin
          state_d = S_START;
          id_d    = ID_MARCH;
        end
      end
      S_START: state_d = S_PLAY;
      S_PLAY: begin
        // Ids 1..3 equal their priority rank, so "higher priority" is "smaller id".
        if (pending_q[0] && (id_q != ID_EXPLODE)) begin
          state_d   = S_START;
          id_d      = ID_EXPLODE;
          grant_clr = 3'b001;
        end else if (((id_q == ID_FIRE) || (id_q == ID_INVADER)) && pend_any &&
                     (pend_id < id_q) && hold_done) begin
          state_d   = S_START;
          id_d      = pend_id;
          grant_clr = pend_mask;
        end else if ((id_q == ID_UFO) && (bus.ufo_hit || !bus.ufo_active)) begin
          if (pend_any) begin
            state_d   = S_START;
            id_d      = pend_id;
            grant_clr = pend_mask;
          end else begin
            state_d = S_GAP;
          end
        end else if ((id_q == ID_MARCH) && (!bus.march_enable || pend_any)) begin
          state_d = S_GAP;
        end else if (one_shot && (guard_q == '0) && bus.theme_ended) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      id_q          <= ID_SILENCE;
      pending_q     <= '0;
      select_q      <= SEL_W'(ID_SILENCE);
      new_track_n_q <= 1'b1;
      busy_q        <= 1'b0;
      guard_q       <= '0;
      hold_q        <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      // A grant and a new pulse in the same cycle leave the request queued.
      pending_q     <= (pending_q & ~grant_clr) | ev_vec;
      new_track_n_q <= (state_d != S_START);
      busy_q        <= (state_d == S_START) || (state_d == S_PLAY);
      select_q      <= ((state_d == S_START) || (state_d == S_PLAY)) ?
                       SEL_W'(id_d) : SEL_W'(ID_SILENCE);

      if (state_d == S_START) begin
        guard_q <= GUARD_W'(GUARD_CYCLES);
        hold_q  <= '0;
      end else if (state_q == S_PLAY) begin
        if (guard_q != '0) guard_q <= guard_q - 1'b1;
        if (hold_q != '1)  hold_q  <= hold_q + 1'b1;
      end

      if ((state_q != S_GAP) && (state_d == S_GAP)) begin
        gap_q <= GAP_W'(GAP_CYCLES - 1);
      end else if ((state_q == S_GAP) && (gap_q != '0)) begin
        gap_q <= gap_q - 1'b1;
      end
    end
  end

  assign bus.select     = select_q;
  assign bus.new_trackN = new_track_n_q;
  assign bus.busy       = busy_q;
  assign bus.pending    = pending_q;

endmodule
